// File: rtl/mux_rr_sel_if.sv
// Handshake bundle between mux_rr_sel, its requesters, the 4:1 mux and the downstream consumer.
// The selector uses the master modport; the surrounding environment uses slave.
interface mux_rr_sel_if #(
    parameter int CNT_W = 8
);
    logic [3:0]       req;
    logic [3:0]       ack;
    logic [1:0]       sel;
    logic [1:0]       mux_f;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       out_data;
    logic [1:0]       out_ch;
    logic             cnt_clr;
    logic [1:0]       cnt_rd_ch;
    logic [CNT_W-1:0] cnt_rd_val;

    modport master (
        input  req, mux_f, out_ready, cnt_clr, cnt_rd_ch,
        output ack, sel, out_valid, out_data, out_ch, cnt_rd_val
    );

    modport slave (
        output req, mux_f, out_ready, cnt_clr, cnt_rd_ch,
        input  ack, sel, out_valid, out_data, out_ch, cnt_rd_val
    );
endinterface

// File: rtl/mux_rr_sel.sv
// Round-robin selector driving a 4:1 mux select, capturing its output into a valid/ready result.
// Optional per-channel saturating grant counters are enabled with `MUX_RR_CNT_EN.
module mux_rr_sel #(
    parameter logic [1:0] START_CH = 2'd0,
    parameter int         CNT_W    = 8
) (
    input logic          clk,
    input logic          rst,
    mux_rr_sel_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        SEL,
        OUT
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] ptr_q, ptr_d;
    logic       out_valid_q, out_valid_d;
    logic [1:0] out_data_q, out_data_d;
    logic [1:0] out_ch_q, out_ch_d;
    logic [3:0] ack_q, ack_d;

    // First set request scanning upward from p; the lowest offset wins.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        rr_pick = p;
        for (int i = 3; i >= 0; i--) begin
            idx = p + 2'(i);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ack_d       = 4'b0000;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    sel_d   = rr_pick(bus.req, ptr_q);
                    state_d = SEL;
                end
            end
            SEL: begin
                out_data_d  = bus.mux_f;
                out_ch_d    = sel_q;
                out_valid_d = 1'b1;
                ack_d       = 4'b0001 << sel_q;
                ptr_d       = sel_q + 2'd1;
                state_d     = OUT;
            end
            OUT: begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    if (|bus.req) begin
                        sel_d   = rr_pick(bus.req, ptr_q);
                        state_d = SEL;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            sel_q       <= START_CH;
            ptr_q       <= START_CH;
            out_valid_q <= 1'b0;
            out_data_q  <= 2'd0;
            out_ch_q    <= 2'd0;
            ack_q       <= 4'b0000;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            ack_q       <= ack_d;
        end
    end

    assign bus.ack       = ack_q;
    assign bus.sel       = sel_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;

`ifdef MUX_RR_CNT_EN
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];

    // Counters see the registered ack, so a clear in the ack cycle still wins.
    always_comb begin
        for (int ch = 0; ch < 4; ch++) begin
            cnt_d[ch] = cnt_q[ch];
            if (bus.cnt_clr) begin
                cnt_d[ch] = '0;
            end else if (ack_q[ch] && (cnt_q[ch] != '1)) begin
                cnt_d[ch] = cnt_q[ch] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int ch = 0; ch < 4; ch++) begin
            if (!rst) begin
                cnt_q[ch] <= '0;
            end else begin
                cnt_q[ch] <= cnt_d[ch];
            end
        end
    end

    assign bus.cnt_rd_val = cnt_q[bus.cnt_rd_ch];
`else
    logic unused_cnt;
    assign unused_cnt     = ^{bus.cnt_clr, bus.cnt_rd_ch};
    assign bus.cnt_rd_val = '0;
`endif

endmodule
